// File: rtl/grid_pkg.sv
// Shared definitions for the flattened grid bus, used by both the packer and the reader
// so the element bit layout stays identical on both sides.
package grid_pkg;

    localparam int DEF_ROWS = 2;
    localparam int DEF_COLS = 3;
    localparam int DEF_W    = 8;

    typedef enum logic {IDLE, SCAN} state_t;

    // Bit offset of element (r,c) inside the flat vector.
    function automatic int elem_lsb(input int r, input int c, input int cols, input int w);
        return (r * cols + c) * w;
    endfunction

endpackage

// File: rtl/grid_rc_counter.sv
// Row-major row/column counter. Wraps to (0,0) after the last element.
module grid_rc_counter #(
    parameter int ROWS = 2,
    parameter int COLS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    localparam logic [7:0] RMAX = 8'(ROWS - 1);
    localparam logic [7:0] CMAX = 8'(COLS - 1);

    assign last = (row == RMAX) && (col == CMAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == CMAX) begin
                col <= '0;
                row <= last ? 8'd0 : row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/grid_flat_reader.sv
// Captures one flat ROWS x COLS grid vector and streams its elements out
// in row-major order, one per output handshake, tagged with row/col.
module grid_flat_reader
    import grid_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int W    = DEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ROWS*COLS*W-1:0] flat_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_row,
    output logic [7:0]           out_col,
    output logic [W-1:0]         out_data,
    output logic                 out_last
);

    localparam int TOTAL = ROWS * COLS * W;

    state_t           state;
    logic [TOTAL-1:0] cap;
    logic [7:0]       row, col;
    logic             cnt_last;
    logic             load_hs, out_hs;
    logic [TOTAL-1:0] shifted;
    int               lsb;

    assign load_hs = load_valid && load_ready;
    assign out_hs  = out_valid && out_ready;

    // The counter wraps to (0,0) by itself on the final handshake.
    grid_rc_counter #(.ROWS(ROWS), .COLS(COLS)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (load_hs),
        .advance (out_hs),
        .row     (row),
        .col     (col),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            cap        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_hs) begin
                        cap        <= flat_in;
                        state      <= SCAN;
                        load_ready <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (out_hs && cnt_last) begin
                        state      <= IDLE;
                        load_ready <= 1'b1;
                        out_valid  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Full-width offset; a shift avoids narrowing the select index.
    always_comb begin
        lsb      = elem_lsb(32'(row), 32'(col), COLS, W);
        shifted  = cap >> lsb;
        out_data = out_valid ? shifted[W-1:0] : '0;
    end

    assign out_row  = row;
    assign out_col  = col;
    assign out_last = out_valid && cnt_last;

endmodule

// File: tb/tb_grid_flat_reader.sv
// Directed bench for grid_flat_reader: default 2x3x8 grid plus a 1x1x4 corner instance.
module tb_grid_flat_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid, load_ready, out_valid, out_ready, out_last;
    logic [47:0] flat_in;
    logic [7:0]  out_row, out_col, out_data;

    logic        load_valid1, load_ready1, out_valid1, out_ready1, out_last1;
    logic [3:0]  flat_in1, out_data1;
    logic [7:0]  out_row1, out_col1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grid_flat_reader #(.ROWS(2), .COLS(3), .W(8)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .flat_in(flat_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_data(out_data), .out_last(out_last)
    );

    grid_flat_reader #(.ROWS(1), .COLS(1), .W(4)) dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid1), .load_ready(load_ready1),
        .flat_in(flat_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_row(out_row1), .out_col(out_col1), .out_data(out_data1), .out_last(out_last1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_elem(input string tag, input int r, input int c, input int d, input bit l);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_row"},   64'(out_row),   64'(r));
        chk({tag, "_col"},   64'(out_col),   64'(c));
        chk({tag, "_data"},  64'(out_data),  64'(d));
        chk({tag, "_last"},  64'(out_last),  64'(l));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_lrdy"},  64'(load_ready), 64'd1);
        chk({tag, "_valid"}, 64'(out_valid),  64'd0);
        chk({tag, "_row"},   64'(out_row),    64'd0);
        chk({tag, "_col"},   64'(out_col),    64'd0);
        chk({tag, "_data"},  64'(out_data),   64'd0);
        chk({tag, "_last"},  64'(out_last),   64'd0);
    endtask

    localparam logic [47:0] V1 = 48'h060504030201;
    localparam logic [47:0] V2 = 48'h0C0B0A090807;

    initial begin
        int n, lasts, acc_edge, idx;
        rst = 1'b1; load_valid = 1'b0; out_ready = 1'b0; flat_in = '0;
        load_valid1 = 1'b0; out_ready1 = 1'b0; flat_in1 = '0;
        repeat (2) tick();
        check_idle("reset");
        chk("reset1_lrdy", 64'(load_ready1), 64'd1);
        chk("reset1_valid", 64'(out_valid1), 64'd0);
        rst = 1'b0;
        tick();

        // Basic scan
        load_valid = 1'b1; flat_in = V1; out_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("basic_lrdy_busy", 64'(load_ready), 64'd0);
        for (int i = 0; i < 6; i++) begin
            check_elem("basic", i / 3, i % 3, i + 1, i == 5);
            tick();
        end
        check_idle("basic_end");

        // Backpressure at (0,2)
        load_valid = 1'b1; flat_in = V1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_elem("bp", i / 3, i % 3, i + 1, i == 5);
            if (i == 2) begin
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check_elem("bp_hold", 0, 2, 3, 1'b0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check_idle("bp_end");

        // Load while busy must be ignored
        load_valid = 1'b1; flat_in = V1;
        tick();
        flat_in = 48'hFFFFFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            chk("busy_lrdy", 64'(load_ready), 64'd0);
            check_elem("busy", i / 3, i % 3, i + 1, i == 5);
            if (i == 5) load_valid = 1'b0;
            tick();
        end
        check_idle("busy_end");

        // Reset mid-scan after (1,0) accepted
        load_valid = 1'b1; flat_in = V1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_elem("prerst", i / 3, i % 3, i + 1, 1'b0);
            tick();
        end
        check_elem("prerst_11", 1, 1, 5, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst");
        load_valid = 1'b1; flat_in = V2;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_elem("postrst", i / 3, i % 3, i + 7, i == 5);
            tick();
        end
        check_idle("postrst_end");

        // Back-to-back loads with load_valid held high
        load_valid = 1'b1; flat_in = V1; out_ready = 1'b1;
        tick();
        n = 1; lasts = 0; acc_edge = 0; idx = 0;
        while (lasts < 2 && n < 40) begin
            if (out_valid) begin
                chk("b2b_data", 64'(out_data), 64'(idx + 1));
                idx++;
                if (lasts == 1 && acc_edge == 0) begin
                    acc_edge = n;
                    load_valid = 1'b0;
                end
                if (out_last) begin
                    lasts++;
                    if (lasts == 1) flat_in = V2;
                end
            end
            if (lasts < 2) begin
                tick();
                n++;
            end
        end
        chk("b2b_accept_edge", 64'(acc_edge), 64'd8);
        chk("b2b_total_cycles", 64'(n + 1), 64'd14);
        chk("b2b_count", 64'(idx), 64'd12);
        load_valid = 1'b0;
        tick();
        check_idle("b2b_end");

        // 1x1 corner
        load_valid1 = 1'b1; flat_in1 = 4'hA; out_ready1 = 1'b1;
        tick();
        load_valid1 = 1'b0;
        chk("c11_valid", 64'(out_valid1), 64'd1);
        chk("c11_row",   64'(out_row1),   64'd0);
        chk("c11_col",   64'(out_col1),   64'd0);
        chk("c11_data",  64'(out_data1),  64'hA);
        chk("c11_last",  64'(out_last1),  64'd1);
        tick();
        chk("c11_idle_valid", 64'(out_valid1), 64'd0);
        chk("c11_idle_lrdy",  64'(load_ready1), 64'd1);
        chk("c11_idle_last",  64'(out_last1),  64'd0);
        chk("c11_idle_data",  64'(out_data1),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grid_flat_reader.md
Name: grid_flat_reader

Overview:
- Reader for the flattened row/column grid bus: the writer side packs a ROWS x COLS array of W-bit elements into one flat vector.
- This block captures one flat vector and emits its elements one per handshake in row-major order.
- Each emitted element carries its row and column index.
- Sits downstream of the grid packer; feeds serial consumers such as monitors and per-element pipelines.

Parameters:
- ROWS, 2, number of rows (1..255)
- COLS, 3, number of columns (1..255)
- W, 8, element width in bits

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  flat_in is valid
- load_ready  out  1  block can accept a new flat vector
- flat_in  in  ROWS*COLS*W  packed grid; element (r,c) occupies bits [(r*COLS+c)*W +: W]
- out_valid  out  1  out_* fields valid
- out_ready  in  1  consumer accepts the element
- out_row  out  8  row index of current element
- out_col  out  8  column index of current element
- out_data  out  W  element value
- out_last  out  1  high with element (ROWS-1, COLS-1)

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, load_ready=1, out_valid=0, out_row=0, out_col=0, out_data=0, out_last=0, captured vector=0.
- A load handshake occurs when load_valid && load_ready on a rising edge.
- An output handshake occurs when out_valid && out_ready on a rising edge.
- State machine:
  - IDLE: load_ready=1, out_valid=0. On a load handshake:
    - capture flat_in into an internal register;
    - set row=0, col=0;
    - go to SCAN.
  - SCAN: load_ready=0, out_valid=1.
    - out_data = captured element (row,col), driven combinationally from the register and counters.
    - out_last = (row==ROWS-1 && col==COLS-1).
    - On an output handshake with out_last=0: col increments; if col==COLS-1, col wraps to 0 and row increments.
    - On an output handshake with out_last=1: go to IDLE; counters return to 0.
- Latency: load accepted at edge N gives out_valid=1 in the cycle after edge N, presenting element (0,0).
- Throughput: one element per cycle under continuous out_ready. ROWS*COLS handshakes per vector, followed by one IDLE cycle before the next load can be accepted.
- Backpressure: while out_valid=1 and out_ready=0, out_row, out_col, out_data and out_last hold stable.
- Loads during SCAN are not accepted (load_ready=0); flat_in is ignored and the captured vector is unchanged.
- out_valid never deasserts in SCAN until the final handshake.
- ROWS=1 or COLS=1: no special case. With ROWS=COLS=1, out_last=1 on the first element.
- Reset in mid-scan: rst wins over any handshake in the same cycle. The next cycle shows the reset values; the partial scan is discarded with no further output.
- Width rules:
  - Counters are 8 bits. Element select is computed as (row*COLS+col)*W at full width; no truncation below clog2(ROWS*COLS*W).
  - out_row and out_col are zero-extended counters.
- No X propagation: out_data=0 whenever out_valid=0.

Decomposition:
- Shared package grid_pkg:
  - default ROWS/COLS/W constants;
  - state typedef {IDLE, SCAN};
  - function elem_lsb(r,c,cols,w) returning (r*cols+c)*w.
- The packer and this reader both use elem_lsb so the bit layout stays in lock-step.
- One natural sub-module: grid_rc_counter, a row-major row/col counter with clear, advance and last outputs, parameterised ROWS/COLS. Reusable by the packer.

Test Plan:
- Basic scan: after reset, load flat_in=48'h060504030201 with out_ready=1.
  - Outputs in consecutive cycles (row,col,data): (0,0,01) (0,1,02) (0,2,03) (1,0,04) (1,1,05) (1,2,06).
  - out_last only on the 6th element; load_ready=1 in the following cycle.
- Backpressure: same vector with out_ready low for 3 cycles at element (0,2). Outputs hold (0,2,03) for those 3 cycles, then the sequence resumes with no loss or duplication.
- Load while busy: during SCAN, drive load_valid=1 with flat_in=48'hFFFFFFFFFFFF. load_ready stays 0 and the emitted data remain 01..06.
- Reset mid-scan: assert rst for one cycle after element (1,0) is accepted.
  - Next cycle: out_valid=0, out_row=0, out_col=0, load_ready=1.
  - A new load of 48'h0C0B0A090807 then emits 07..0C starting at (0,0).
- Back-to-back: hold load_valid=1 with two vectors.
  - The second load is accepted exactly one cycle after the first vector's out_last handshake.
  - Total of 14 cycles from the first load edge to the last handshake with out_ready=1.
- Parameter corner: ROWS=1, COLS=1, W=4, flat_in=4'hA. One element (0,0,A) with out_last=1, then IDLE.
